// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared bus types, arbiter states and owner encoding
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4} msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_select.sv
// rtl/mem_bus_arbiter_select.sv - combinational grant: dbus first unless fetch is starved
module mem_bus_arbiter_select
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       ivalid_i,
  input  logic       dvalid_i,
  input  logic [7:0] starve_cnt_i,
  output logic       grant_o,
  output logic       owner_o
);

  logic starved;

  assign starved = ivalid_i && (starve_cnt_i == 8'(STARVE_LIMIT));
  assign grant_o = ivalid_i || dvalid_i;
  assign owner_o = (dvalid_i && !starved) ? OWNER_D : OWNER_I;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter sharing one memory port between ibus and dbus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp
);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;

  logic       grant, grant_owner;
  logic       cur_owner, route;
  logic       owner_valid;
  dbus_req_t  ipay;

  mem_bus_arbiter_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .ivalid_i     (ireq.valid),
    .dvalid_i     (dreq.valid),
    .starve_cnt_i (starve_cnt_q),
    .grant_o      (grant),
    .owner_o      (grant_owner)
  );

  always_comb begin
    ipay       = '0;
    ipay.valid = ireq.valid;
    ipay.addr  = ireq.addr;
    ipay.size  = MSIZE4;
  end

  assign owner_valid = (owner_q == OWNER_D) ? dreq.valid : ireq.valid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    cur_owner    = owner_q;
    route        = 1'b0;
    mreq         = '0;
    case (state_q)
      ARB_IDLE: begin
        cur_owner = grant_owner;
        if (grant) begin
          owner_d = grant_owner;
          mreq    = (grant_owner == OWNER_D) ? dreq : ipay;
          route   = 1'b1;
          if (mresp.addr_ok && !mresp.data_ok) state_d = ARB_DATA;
          else if (!mresp.addr_ok)            state_d = ARB_ADDR;
        end
        if (!ireq.valid || (grant && grant_owner == OWNER_I)) begin
          starve_cnt_d = '0;
        end else if (grant && starve_cnt_q != 8'(STARVE_LIMIT)) begin
          starve_cnt_d = starve_cnt_q + 8'd1;
        end
      end
      ARB_ADDR: begin
        // A flushed owner abandons the request before it was accepted.
        if (!owner_valid) begin
          state_d = ARB_IDLE;
        end else begin
          mreq  = (owner_q == OWNER_D) ? dreq : ipay;
          route = 1'b1;
          if (mresp.addr_ok && mresp.data_ok) state_d = ARB_IDLE;
          else if (mresp.addr_ok)             state_d = ARB_DATA;
        end
      end
      ARB_DATA: begin
        route = 1'b1;
        if (mresp.data_ok) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (!resetn) begin
      mreq.valid = 1'b0;
      route      = 1'b0;
    end
  end

  always_comb begin
    iresp.addr_ok = route && (cur_owner == OWNER_I) && mresp.addr_ok;
    iresp.data_ok = route && (cur_owner == OWNER_I) && mresp.data_ok;
    iresp.data    = mresp.data;
    dresp.addr_ok = route && (cur_owner == OWNER_D) && mresp.addr_ok;
    dresp.data_ok = route && (cur_owner == OWNER_D) && mresp.data_ok;
    dresp.data    = mresp.data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_I;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cnt_m;
  logic       exp_own;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireq   (ireq),
    .iresp  (iresp),
    .dreq   (dreq),
    .dresp  (dresp),
    .mreq   (mreq),
    .mresp  (mresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (dresp.data_ok || iresp.data_ok) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_data_ok", {30'd0, iresp.data_ok, dresp.data_ok}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_both_ok", 32'(dresp.data_ok && iresp.data_ok), 32'd0);
        check_eq("sb_owner", 32'(dresp.data_ok), 32'(e.owner));
        check_eq("sb_data", e.owner ? dresp.data : iresp.data, e.data);
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mresp(input logic a, input logic d, input logic [31:0] data);
    mresp.addr_ok = a;
    mresp.data_ok = d;
    mresp.data    = data;
  endtask

  initial begin
    resetn = 1'b0;
    ireq   = '0;
    dreq   = '0;
    set_mresp(1'b1, 1'b1, 32'h0);
    dreq.valid = 1'b1;
    #2;
    check_eq("rst_mreq_valid", 32'(mreq.valid), 32'd0);
    check_eq("rst_dresp_ok", {30'd0, dresp.addr_ok, dresp.data_ok}, 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    check_eq("rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
    dreq = '0;
    set_mresp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // single dbus load, one-cycle response
    dreq = '{valid: 1'b1, addr: 32'h100, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    set_mresp(1'b1, 1'b1, 32'hDEADBEEF);
    sb_q.push_back('{owner: OWNER_D, data: 32'hDEADBEEF});
    settle();
    check_eq("t1_mreq_valid", 32'(mreq.valid), 32'd1);
    check_eq("t1_mreq_addr", mreq.addr, 32'h100);
    check_eq("t1_dresp_data_ok", 32'(dresp.data_ok), 32'd1);
    check_eq("t1_dresp_data", dresp.data, 32'hDEADBEEF);
    end_cycle();
    check_eq("t1_state", 32'(dut.state_q), 32'(ARB_IDLE));
    dreq = '0;
    set_mresp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    // both valid, dbus wins, addr_ok at cycle 2, data_ok at cycle 5
    ireq = '{valid: 1'b1, addr: 32'h2000};
    dreq = '{valid: 1'b1, addr: 32'h300, size: MSIZE2, strobe: 4'h3, data: 32'h77};
    sb_q.push_back('{owner: OWNER_D, data: 32'h55});
    for (int c = 0; c < 6; c++) begin
      set_mresp(c == 2, c == 5, (c == 5) ? 32'h55 : 32'h0);
      settle();
      check_eq("t2_iresp_ok", {30'd0, iresp.addr_ok, iresp.data_ok}, 32'd0);
      check_eq("t2_mreq_valid", 32'(mreq.valid), 32'(c <= 2));
      check_eq("t2_dresp_addr_ok", 32'(dresp.addr_ok), 32'(c == 2));
      if (c == 0) check_eq("t2_mreq_addr", mreq.addr, 32'h300);
      end_cycle();
    end
    dreq = '0;
    set_mresp(1'b1, 1'b1, 32'h1234);
    sb_q.push_back('{owner: OWNER_I, data: 32'h1234});
    settle();
    check_eq("t2_i_grant_addr", mreq.addr, 32'h2000);
    check_eq("t2_i_size", 32'(mreq.size), 32'(MSIZE4));
    check_eq("t2_i_addr_ok", 32'(iresp.addr_ok), 32'd1);
    end_cycle();
    ireq = '0;
    set_mresp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    // starvation: dbus always valid, ibus must win the 9th grant
    cnt_m = 0;
    ireq  = '{valid: 1'b1, addr: 32'h4000};
    dreq  = '{valid: 1'b1, addr: 32'h500, size: MSIZE1, strobe: 4'h1, data: 32'hAA};
    for (int k = 0; k < 10; k++) begin
      exp_own = (cnt_m == 8) ? OWNER_I : OWNER_D;
      set_mresp(1'b1, 1'b1, 32'h100 + 32'(k));
      sb_q.push_back('{owner: exp_own, data: 32'h100 + 32'(k)});
      settle();
      check_eq("t3_dresp_addr_ok", 32'(dresp.addr_ok), 32'(exp_own == OWNER_D));
      check_eq("t3_iresp_addr_ok", 32'(iresp.addr_ok), 32'(exp_own == OWNER_I));
      if (exp_own == OWNER_I) begin
        check_eq("t3_i_size", 32'(mreq.size), 32'(MSIZE4));
        check_eq("t3_i_strobe", 32'(mreq.strobe), 32'd0);
        check_eq("t3_i_data", mreq.data, 32'd0);
        check_eq("t3_i_addr", mreq.addr, 32'h4000);
      end
      end_cycle();
      if (exp_own == OWNER_I) begin
        cnt_m = 0;
        check_eq("t3_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
      end else if (cnt_m < 8) begin
        cnt_m++;
      end
    end
    check_eq("t3_cnt_final", 32'(dut.starve_cnt_q), 32'(cnt_m));
    ireq = '0;
    dreq = '0;
    set_mresp(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;

    // flush while waiting for addr_ok
    dreq = '{valid: 1'b1, addr: 32'h600, size: MSIZE4, strobe: 4'hF, data: 32'h1};
    settle();
    end_cycle();
    check_eq("t4_state_addr", 32'(dut.state_q), 32'(ARB_ADDR));
    dreq.valid = 1'b0;
    settle();
    check_eq("t4_mreq_valid", 32'(mreq.valid), 32'd0);
    check_eq("t4_dresp_ok", {30'd0, dresp.addr_ok, dresp.data_ok}, 32'd0);
    end_cycle();
    check_eq("t4_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
    dreq = '0;

    // reset while in DATA; late data_ok must not reach anyone
    dreq = '{valid: 1'b1, addr: 32'h700, size: MSIZE4, strobe: 4'h0, data: 32'h0};
    set_mresp(1'b1, 1'b0, 32'h0);
    settle();
    end_cycle();
    check_eq("t5_state_data", 32'(dut.state_q), 32'(ARB_DATA));
    set_mresp(1'b0, 1'b1, 32'h99);
    resetn = 1'b0;
    #1;
    check_eq("t5_rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    check_eq("t5_rst_mreq_valid", 32'(mreq.valid), 32'd0);
    check_eq("t5_rst_ok", {28'd0, iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}, 32'd0);
    dreq = '0;
    resetn = 1'b1;
    settle();
    check_eq("t5_late_ok", {28'd0, iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}, 32'd0);
    end_cycle();
    set_mresp(1'b0, 1'b0, 32'h0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
